// File: rtl/srio_pkt_router.sv
`default_nettype none
// ============================================================================
// Module   : srio_pkt_router
// Purpose  : Routes SRIO packets by header FTYPE to a TDEST or drops them.
// Revision : 1.0
// ============================================================================
module srio_pkt_router #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 32,
    parameter int DEST_WIDTH = 2,
    parameter int FTYPE_LSB  = 52
) (
    input  logic                     AXIS_ACLK,
    input  logic                     AXIS_ARESET,
    input  logic                     S_AXIS_TVALID,
    output logic                     S_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic                     S_AXIS_TLAST,
    input  logic [USER_WIDTH-1:0]    S_AXIS_TUSER,
    output logic                     M_AXIS_TVALID,
    input  logic                     M_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic                     M_AXIS_TLAST,
    output logic [USER_WIDTH-1:0]    M_AXIS_TUSER,
    output logic [DEST_WIDTH-1:0]    M_AXIS_TDEST,
    input  logic [16*DEST_WIDTH-1:0] ROUTE_TABLE,
    input  logic [15:0]              ROUTE_EN,
    output logic [31:0]              FWD_CNT,
    output logic [15:0]              DROP_CNT
);

    localparam int c_EW = DATA_WIDTH + USER_WIDTH + DEST_WIDTH + 1;

    localparam logic [1:0] S_HDR  = 2'd0;
    localparam logic [1:0] S_FWD  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [1:0]            r_count;
    logic [1:0]            w_count_nxt;
    logic                  r_s_tready;
    logic [c_EW-1:0]       r_head;
    logic [c_EW-1:0]       r_skid;
    logic [c_EW-1:0]       w_beat;
    logic [DEST_WIDTH-1:0] r_dest;
    logic [DEST_WIDTH-1:0] w_dest;
    logic                  r_drop;
    logic                  w_drop;
    logic [3:0]            w_ftype;
    logic                  w_hdr;
    logic                  w_s_xfer;
    logic                  w_m_xfer;
    logic                  w_push;
    logic [31:0]           r_fwd_cnt;
    logic [15:0]           r_drop_cnt;

    assign w_ftype  = S_AXIS_TDATA[FTYPE_LSB +: 4];
    assign w_hdr    = (r_state == S_HDR);
    assign w_s_xfer = S_AXIS_TVALID & r_s_tready;
    assign w_m_xfer = (r_count != 2'd0) & M_AXIS_TREADY;
    assign w_push   = w_s_xfer & ~w_drop;
    assign w_beat   = {S_AXIS_TLAST, S_AXIS_TUSER, w_dest, S_AXIS_TDATA};

    // Routing decision is live only on the header; body beats reuse the latched copy.
    always_comb begin
        w_dest = r_dest;
        w_drop = r_drop;
        if (w_hdr) begin
            w_dest = ROUTE_TABLE[w_ftype*DEST_WIDTH +: DEST_WIDTH];
            w_drop = ~ROUTE_EN[w_ftype];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_s_xfer) begin
            case (r_state)
                S_HDR:   if (!S_AXIS_TLAST) w_state_nxt = w_drop ? S_DROP : S_FWD;
                S_FWD,
                S_DROP:  if (S_AXIS_TLAST) w_state_nxt = S_HDR;
                default: w_state_nxt = S_HDR;
            endcase
        end else if (r_state == 2'd3) begin
            w_state_nxt = S_HDR;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_m_xfer})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            r_state    <= S_HDR;
            r_count    <= 2'd0;
            r_s_tready <= 1'b0;
            r_head     <= '0;
            r_skid     <= '0;
            r_dest     <= '0;
            r_drop     <= 1'b0;
            r_fwd_cnt  <= 32'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_s_tready <= (w_count_nxt < 2'd2);
            if (w_s_xfer && w_hdr) begin
                r_dest <= w_dest;
                r_drop <= w_drop;
            end
            // Pushes only occur with occupancy below two since TREADY tracks it.
            if (w_push && (r_count == 2'd0 || (r_count == 2'd1 && w_m_xfer))) begin
                r_head <= w_beat;
            end else if (w_m_xfer && r_count == 2'd2) begin
                r_head <= r_skid;
            end
            if (w_push && r_count == 2'd1 && !w_m_xfer) begin
                r_skid <= w_beat;
            end
            if (w_m_xfer && M_AXIS_TLAST) begin
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
            end
            if (w_s_xfer && w_hdr && w_drop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign S_AXIS_TREADY = r_s_tready;
    assign M_AXIS_TVALID = (r_count != 2'd0);
    assign M_AXIS_TDATA  = r_head[DATA_WIDTH-1:0];
    assign M_AXIS_TDEST  = r_head[DATA_WIDTH +: DEST_WIDTH];
    assign M_AXIS_TUSER  = r_head[DATA_WIDTH+DEST_WIDTH +: USER_WIDTH];
    assign M_AXIS_TLAST  = r_head[c_EW-1];
    assign FWD_CNT       = r_fwd_cnt;
    assign DROP_CNT      = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_srio_pkt_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_srio_pkt_router
// Purpose  : Directed self-checking bench for srio_pkt_router.
// Revision : 1.0
// ============================================================================
module tb_srio_pkt_router;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic [31:0] s_tuser = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [63:0] m_tdata;
    logic        m_tlast;
    logic [31:0] m_tuser;
    logic [1:0]  m_tdest;
    logic [31:0] route_table = '0;
    logic [15:0] route_en = 16'hFFFF;
    logic [31:0] fwd_cnt;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hdr_cyc = 0;

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic [31:0] u;
        logic [1:0]  dst;
        int          c;
    } beat_t;
    beat_t got_q[$];

    srio_pkt_router dut (
        .AXIS_ACLK     (aclk),
        .AXIS_ARESET   (areset),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TREADY (s_tready),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TUSER  (s_tuser),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TREADY (m_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TUSER  (m_tuser),
        .M_AXIS_TDEST  (m_tdest),
        .ROUTE_TABLE   (route_table),
        .ROUTE_EN      (route_en),
        .FWD_CNT       (fwd_cnt),
        .DROP_CNT      (drop_cnt)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Master transfers complete on the following posedge; inputs only move at posedge+1.
    always @(negedge aclk) begin
        if (!areset && m_tvalid && m_tready)
            got_q.push_back('{m_tdata, m_tlast, m_tuser, m_tdest, cyc});
    end

    function automatic logic [63:0] mk_data(input logic [3:0] ft, input logic [7:0] tag, input logic [7:0] idx);
        logic [63:0] d;
        d = 64'hA500_0000_0000_0000;
        d[55:52] = ft;
        d[15:8]  = tag;
        d[7:0]   = idx;
        return d;
    endfunction

    function automatic logic [31:0] mk_user(input logic [7:0] tag, input logic [7:0] idx);
        return {16'hBEEF, tag, idx};
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic l, input logic [31:0] u);
        bit acc;
        acc = 1'b0;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = l; s_tuser = u;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge aclk);
            if (s_tready) begin
                acc = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge aclk); #1;
        end
        s_tvalid = 1'b0;
        if (!acc) begin
            errors++; checks++;
            $display("FAIL send_timeout: beat %h never accepted", d);
        end
    endtask

    task automatic send_pkt(input logic [3:0] ft, input int nb, input logic [7:0] tag);
        for (int i = 0; i < nb; i++) begin
            send_beat(mk_data(ft, tag, 8'(i)), (i == nb - 1), mk_user(tag, 8'(i)));
            if (i == 0) hdr_cyc = acc_cyc;
        end
    endtask

    task automatic drain();
        repeat (10) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk); #1;
        got_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", s_tready); end
        checks++; if (fwd_cnt !== 32'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", fwd_cnt, drop_cnt); end
        checks++; if ({m_tdata, m_tlast, m_tuser, m_tdest} !== '0) begin errors++; $display("FAIL rst_mdata: got %h want 0", m_tdata); end
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready_pre: got %b want 0", s_tready); end
        @(negedge aclk);
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_tready_up: got %b want 1", s_tready); end
        @(posedge aclk); #1;
    endtask

    task automatic test_forward();
        do_reset();
        route_table[13:12] = 2'd2; route_en = 16'hFFFF;
        send_pkt(4'd6, 4, 8'h01);
        drain();
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL fwd_count_beats: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].d !== mk_data(4'd6, 8'h01, 8'(i)) || got_q[i].u !== mk_user(8'h01, 8'(i)) ||
                got_q[i].dst !== 2'd2 || got_q[i].l !== (i == 3)) begin
                errors++;
                $display("FAIL fwd_beat%0d: got d=%h u=%h dst=%0d l=%b want d=%h dst=2 l=%b",
                         i, got_q[i].d, got_q[i].u, got_q[i].dst, got_q[i].l, mk_data(4'd6, 8'h01, 8'(i)), (i == 3));
            end
            checks++;
            if (got_q[i].c != hdr_cyc + 1 + i) begin
                errors++; $display("FAIL fwd_timing%0d: got cycle %0d want %0d", i, got_q[i].c, hdr_cyc + 1 + i);
            end
        end
        checks++; if (fwd_cnt !== 32'd1) begin errors++; $display("FAIL fwd_cnt: got %0d want 1", fwd_cnt); end
    endtask

    task automatic test_drop();
        do_reset();
        route_table[13:12] = 2'd2; route_en = 16'hFFFF; route_en[9] = 1'b0;
        send_pkt(4'd9, 3, 8'h02);
        send_pkt(4'd6, 1, 8'h03);
        drain();
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL drop_beats: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0].d !== mk_data(4'd6, 8'h03, 8'd0) || got_q[0].l !== 1'b1 || got_q[0].dst !== 2'd2) begin
                errors++; $display("FAIL drop_single: got d=%h l=%b dst=%0d want d=%h l=1 dst=2",
                                   got_q[0].d, got_q[0].l, got_q[0].dst, mk_data(4'd6, 8'h03, 8'd0));
            end
        end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt); end
        checks++; if (fwd_cnt !== 32'd1) begin errors++; $display("FAIL drop_fwd_cnt: got %0d want 1", fwd_cnt); end
    endtask

    task automatic test_backpressure();
        logic [98:0] snap;
        do_reset();
        route_table[13:12] = 2'd2; route_en = 16'hFFFF;
        fork
            send_pkt(4'd6, 8, 8'h04);
            begin
                repeat (3) @(posedge aclk);
                #1 m_tready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge aclk);
                    if (i == 0) snap = {m_tdata, m_tlast, m_tuser, m_tdest};
                    checks++;
                    if (s_tready !== (i == 0)) begin
                        errors++; $display("FAIL bp_tready%0d: got %b want %b", i, s_tready, (i == 0));
                    end
                    checks++;
                    if (m_tvalid !== 1'b1 || {m_tdata, m_tlast, m_tuser, m_tdest} !== snap) begin
                        errors++; $display("FAIL bp_stable%0d: got v=%b d=%h want v=1 d=%h", i, m_tvalid, m_tdata, snap[98:35]);
                    end
                end
                @(posedge aclk); #1 m_tready = 1'b1;
            end
        join
        drain();
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL bp_beats: got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].d !== mk_data(4'd6, 8'h04, 8'(i)) || got_q[i].l !== (i == 7)) begin
                errors++; $display("FAIL bp_order%0d: got d=%h l=%b want d=%h l=%b",
                                   i, got_q[i].d, got_q[i].l, mk_data(4'd6, 8'h04, 8'(i)), (i == 7));
            end
        end
        checks++; if (fwd_cnt !== 32'd1) begin errors++; $display("FAIL bp_fwd_cnt: got %0d want 1", fwd_cnt); end
    endtask

    task automatic test_route_change();
        do_reset();
        route_table[13:12] = 2'd1; route_en = 16'hFFFF;
        send_beat(mk_data(4'd6, 8'h05, 8'd0), 1'b0, mk_user(8'h05, 8'd0));
        route_table[13:12] = 2'd3; route_en[6] = 1'b0;
        for (int i = 1; i < 4; i++) send_beat(mk_data(4'd6, 8'h05, 8'(i)), (i == 3), mk_user(8'h05, 8'(i)));
        route_en[6] = 1'b1;
        send_pkt(4'd6, 1, 8'h06);
        drain();
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL rc_beats: got %0d want 5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].dst !== ((i < 4) ? 2'd1 : 2'd3)) begin
                errors++; $display("FAIL rc_dest%0d: got %0d want %0d", i, got_q[i].dst, (i < 4) ? 1 : 3);
            end
        end
        checks++; if (fwd_cnt !== 32'd2 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rc_cnt: got %0d/%0d want 2/0", fwd_cnt, drop_cnt); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        route_table[13:12] = 2'd2; route_en = 16'hFFFF; route_en[9] = 1'b0;
        send_pkt(4'd6, 1, 8'h07);
        send_pkt(4'd9, 1, 8'h08);
        drain();
        checks++; if (fwd_cnt !== 32'd1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL rm_pre_cnt: got %0d/%0d want 1/1", fwd_cnt, drop_cnt); end
        m_tready = 1'b0;
        send_beat(mk_data(4'd6, 8'h09, 8'd0), 1'b0, mk_user(8'h09, 8'd0));
        s_tvalid = 1'b1; s_tdata = mk_data(4'd6, 8'h09, 8'd1); s_tlast = 1'b0;
        areset = 1'b1; route_table[13:12] = 2'd1;
        @(posedge aclk);
        @(negedge aclk);
        checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin errors++; $display("FAIL rm_valid: got v=%b r=%b want 0/0", m_tvalid, s_tready); end
        checks++; if (fwd_cnt !== 32'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rm_cnt: got %0d/%0d want 0/0", fwd_cnt, drop_cnt); end
        @(posedge aclk); #1;
        areset = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
        got_q.delete();
        send_pkt(4'd6, 2, 8'h0A);
        drain();
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL rm_beats: got %0d want 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].d !== mk_data(4'd6, 8'h0A, 8'(i)) || got_q[i].dst !== 2'd1 || got_q[i].l !== (i == 1)) begin
                errors++; $display("FAIL rm_beat%0d: got d=%h dst=%0d l=%b want d=%h dst=1 l=%b",
                                   i, got_q[i].d, got_q[i].dst, got_q[i].l, mk_data(4'd6, 8'h0A, 8'(i)), (i == 1));
            end
        end
        checks++; if (fwd_cnt !== 32'd1) begin errors++; $display("FAIL rm_fwd_cnt: got %0d want 1", fwd_cnt); end
    endtask

    task automatic test_drop_saturation();
        int n;
        do_reset();
        route_en = 16'hFFFF; route_en[9] = 1'b0;
        n = 0;
        s_tvalid = 1'b1; s_tdata = mk_data(4'd9, 8'h0B, 8'd0); s_tlast = 1'b1; s_tuser = mk_user(8'h0B, 8'd0);
        for (int g = 0; g < 75000 && n < 70000; g++) begin
            @(negedge aclk);
            if (s_tready) begin
                if (n == 1000 || n == 65534) begin
                    checks++;
                    if (drop_cnt !== 16'(n)) begin errors++; $display("FAIL sat_mid: got %0d want %0d", drop_cnt, n); end
                end
                n++;
            end
        end
        @(posedge aclk); #1 s_tvalid = 1'b0;
        checks++; if (n != 70000) begin errors++; $display("FAIL sat_accept: got %0d want 70000", n); end
        @(negedge aclk);
        checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt: got %h want ffff", drop_cnt); end
        checks++; if (fwd_cnt !== 32'd0 || got_q.size() != 0) begin errors++; $display("FAIL sat_leak: got fwd=%0d beats=%0d want 0/0", fwd_cnt, got_q.size()); end
        @(posedge aclk); #1;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_drop();
        test_backpressure();
        test_route_change();
        test_reset_mid_packet();
        test_drop_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/srio_pkt_router.md
SRIO_PKT_ROUTER -- requirements
Module: srio_pkt_router

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the TDATA width in bits (minimum 64).
REQ-002 SHALL have parameter USER_WIDTH, default 32, meaning the TUSER width.
REQ-003 SHALL have parameter DEST_WIDTH, default 2, meaning the TDEST width; 2^DEST_WIDTH downstream ports.
REQ-004 SHALL have parameter FTYPE_LSB, default 52, meaning the LSB of the 4-bit FTYPE field in the header beat.
REQ-005 SHALL have one clock and synchronous active-high reset: AXIS_ACLK (in, 1, clock) and AXIS_ARESET (in, 1, synchronous active-high reset).
REQ-006 SHALL have the slave port: S_AXIS_TVALID in 1; S_AXIS_TREADY out 1; S_AXIS_TDATA in DATA_WIDTH; S_AXIS_TLAST in 1; S_AXIS_TUSER in USER_WIDTH.
REQ-007 SHALL have the master port: M_AXIS_TVALID out 1; M_AXIS_TREADY in 1; M_AXIS_TDATA out DATA_WIDTH; M_AXIS_TLAST out 1; M_AXIS_TUSER out USER_WIDTH; M_AXIS_TDEST out DEST_WIDTH.
REQ-008 SHALL have ROUTE_TABLE in 16*DEST_WIDTH, giving the destination for FTYPE f at bits [f*DEST_WIDTH +: DEST_WIDTH].
REQ-009 SHALL have ROUTE_EN in 16, where bit f=1 forwards FTYPE f and bit f=0 drops it.
REQ-010 SHALL have FWD_CNT out 32 (forwarded packets) and DROP_CNT out 16 (dropped packets).

Function
REQ-011 SHALL classify a beat as the header when it is the first beat accepted after reset or the first beat accepted after a beat with TLAST.
REQ-012 SHALL take ftype = S_AXIS_TDATA[FTYPE_LSB+3:FTYPE_LSB] of the header, with dest = ROUTE_TABLE slice and drop = ~ROUTE_EN[ftype], both sampled only on the header transfer.
REQ-013 SHALL hold dest and drop constant for every beat of the packet; ROUTE_TABLE/ROUTE_EN changes mid-packet SHALL apply only from the next header.
REQ-014 SHALL implement a packet FSM: S_HDR (awaiting header); S_FWD (forwarding body); S_DROP (discarding body).
REQ-015 SHALL make FSM transitions on slave transfer only: S_HDR→S_FWD if !drop&!TLAST; S_HDR→S_DROP if drop&!TLAST; S_HDR stays if TLAST; S_FWD/S_DROP→S_HDR on TLAST.
REQ-016 SHALL place forwarded beats (data, last, user, dest) into a 2-entry skid buffer; M_AXIS_* SHALL present the head entry.
REQ-017 SHALL drive S_AXIS_TREADY from a register: 1 when buffer occupancy <2 after the current cycle's updates; no combinational path from M_AXIS_TREADY.
REQ-018 SHALL give latency of 1 cycle: a beat accepted in cycle N appears on M_AXIS_* in cycle N+1 when the buffer was empty.
REQ-019 SHALL sustain throughput of 1 beat/cycle with M_AXIS_TREADY held high; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-020 SHALL keep M_AXIS_* stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0 (AXI-Stream rule).
REQ-021 SHALL accept dropped-packet beats (subject to TREADY) and never write them to the buffer or present them on the master.
REQ-022 SHALL handle single-beat packets (header with TLAST) per drop: forwarded with TLAST=1, or dropped.
REQ-023 SHALL increment DROP_CNT on each dropped header transfer, saturating at 0xFFFF.
REQ-024 SHALL increment FWD_CNT on each master transfer with M_AXIS_TLAST=1, wrapping modulo 2^32.
REQ-025 SHALL make no assumption of TUSER content; it SHALL pass through unchanged with its beat.

Reset
REQ-026 SHALL, while AXIS_ARESET=1 at a clock edge, force: M_AXIS_TVALID=0, S_AXIS_TREADY=0, occupancy=0, FSM=S_HDR, FWD_CNT=0, DROP_CNT=0, M_AXIS_TDATA/TUSER/TDEST/TLAST=0.
REQ-027 SHALL discard in-flight buffered beats on reset mid-packet, raise S_AXIS_TREADY=1 the first cycle after reset deasserts, and treat the next accepted beat as a header.

Verification
REQ-028 SHALL cover: ROUTE_TABLE[6]=2, EN[6]=1, 4-beat packet with TDATA[55:52]=6 and TREADY high -> 4 beats with TDEST=2 at 1/cycle, TLAST on beat 4, FWD_CNT=1.
REQ-029 SHALL cover: EN[9]=0, 3-beat FTYPE 9 packet then 1-beat FTYPE 6 packet -> only the FTYPE 6 beat appears, DROP_CNT=1, FWD_CNT=1.
REQ-030 SHALL cover: M_AXIS_TREADY=0 for 5 cycles during streaming -> S_AXIS_TREADY=0 after 2 beats buffered, no beat lost or duplicated, master outputs stable.
REQ-031 SHALL cover: ROUTE_TABLE[6] changed 1→3 after the header of a 4-beat packet -> all 4 beats TDEST=1, and the next packet TDEST=3.
REQ-032 SHALL cover: AXIS_ARESET pulsed on beat 2 of a 4-beat packet -> M_AXIS_TVALID=0 next cycle, counters 0, and the following beat (FTYPE 6) routed as a header.
REQ-033 SHALL cover: 70000 dropped single-beat packets -> DROP_CNT=0xFFFF.
